// File: rtl/hiscore_ram_arbiter.sv
// Arbitrates one game-RAM port between the running core and the hiscore engine.
// The core is paused and allowed to settle before the hiscore side gets the port.
module hiscore_ram_arbiter #(
  parameter int unsigned ADDRESSWIDTH   = 10,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned RELEASE_CYCLES = 2,
  parameter int unsigned MAX_GRANT      = 65535,
  parameter int unsigned VBLANK_GATE    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    vblank,
  input  logic                    hs_req,
  input  logic [ADDRESSWIDTH-1:0] hs_address,
  input  logic [7:0]              hs_data,
  input  logic                    hs_write,
  output logic                    hs_grant,
  input  logic [ADDRESSWIDTH-1:0] core_address,
  input  logic [7:0]              core_data,
  input  logic                    core_write,
  output logic [ADDRESSWIDTH-1:0] ram_address,
  output logic [7:0]              ram_data,
  output logic                    ram_we,
  output logic                    pause,
  output logic                    timeout,
  output logic [7:0]              dropped_writes
);

  localparam int unsigned WdWidth = (MAX_GRANT < 2) ? 1 : $clog2(MAX_GRANT + 1);

  typedef enum logic [1:0] {StIdle, StPausing, StGranted, StRelease} state_e;

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [WdWidth-1:0] wd_q, wd_d;
  logic               timeout_q, timeout_d;
  logic               block_q, block_d;
  logic [7:0]         dropped_q, dropped_d;
  logic               gate_open;

  assign gate_open = vblank || (VBLANK_GATE == 0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wd_d      = wd_q;
    timeout_d = timeout_q;
    // After a watchdog release, a new request needs hs_req to have dropped once.
    block_d   = block_q && hs_req;
    dropped_d = dropped_q;

    unique case (state_q)
      StIdle: begin
        if (hs_req && gate_open && !block_q) begin
          state_d = StPausing;
          cnt_d   = 8'(SETTLE_CYCLES - 1);
        end
      end
      StPausing: begin
        if (!hs_req) begin
          state_d = StIdle;
        end else if (cnt_q == 8'd0) begin
          state_d = StGranted;
          wd_d    = '0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StGranted: begin
        wd_d = wd_q + 1'b1;
        if (!hs_req) begin
          state_d = StRelease;
          cnt_d   = 8'(RELEASE_CYCLES - 1);
        end else if (wd_q == WdWidth'(MAX_GRANT - 1)) begin
          state_d   = StRelease;
          cnt_d     = 8'(RELEASE_CYCLES - 1);
          timeout_d = 1'b1;
          block_d   = 1'b1;
        end
      end
      StRelease: begin
        if (cnt_q == 8'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if ((state_q == StGranted || state_q == StRelease) && core_write && dropped_q != 8'hFF) begin
      dropped_d = dropped_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
      block_q   <= 1'b0;
      dropped_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
      block_q   <= block_d;
      dropped_q <= dropped_d;
    end
  end

  assign pause          = (state_q != StIdle);
  assign hs_grant       = (state_q == StGranted);
  assign timeout        = timeout_q;
  assign dropped_writes = dropped_q;

  always_comb begin
    ram_address = core_address;
    ram_data    = core_data;
    ram_we      = core_write;
    if (state_q == StGranted) begin
      ram_address = hs_address;
      ram_data    = hs_data;
      ram_we      = hs_write;
    end else if (state_q == StRelease) begin
      ram_we = 1'b0;
    end
  end

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Bench for hiscore_ram_arbiter: directed vector table, multi-cycle sequences and
// randomized traffic compared against a phase/elapsed-time reference model.
module tb_hiscore_ram_arbiter;

  localparam int AW     = 10;
  localparam int SETTLE = 4;
  localparam int REL    = 2;
  localparam int MAXG   = 16;

  logic          clk = 1'b0;
  logic          reset, vblank, hs_req, hs_write, core_write;
  logic [AW-1:0] hs_address, core_address;
  logic [7:0]    hs_data, core_data;
  logic          hs_grant, ram_we, pause, timeout;
  logic [AW-1:0] ram_address;
  logic [7:0]    ram_data, dropped_writes;

  int checks = 0;
  int errors = 0;

  hiscore_ram_arbiter #(
    .ADDRESSWIDTH  (AW),
    .SETTLE_CYCLES (SETTLE),
    .RELEASE_CYCLES(REL),
    .MAX_GRANT     (MAXG),
    .VBLANK_GATE   (1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .vblank        (vblank),
    .hs_req        (hs_req),
    .hs_address    (hs_address),
    .hs_data       (hs_data),
    .hs_write      (hs_write),
    .hs_grant      (hs_grant),
    .core_address  (core_address),
    .core_data     (core_data),
    .core_write    (core_write),
    .ram_address   (ram_address),
    .ram_data      (ram_data),
    .ram_we        (ram_we),
    .pause         (pause),
    .timeout       (timeout),
    .dropped_writes(dropped_writes)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vb, req, cw, hw;
    logic       ep, eg, ewe;
    logic [7:0] edrop;
  } vec_t;

  vec_t vecs[16];

  // Reference model: phase 0 idle, 1 settling, 2 owned by hiscore, 3 winding down.
  int         m_phase, m_elapsed;
  logic       m_timeout, m_block;
  int         m_drop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_phase = 0; m_elapsed = 0; m_timeout = 1'b0; m_block = 1'b0; m_drop = 0;
  endtask

  task automatic model_step();
    int   nphase, nel;
    logic fired;
    nphase = m_phase; nel = m_elapsed + 1; fired = 1'b0;
    if (m_phase >= 2 && core_write && m_drop < 255) m_drop++;
    case (m_phase)
      0: if (hs_req && vblank && !m_block) begin nphase = 1; nel = 0; end
      1: if (!hs_req) nphase = 0;
         else if (m_elapsed == SETTLE - 1) begin nphase = 2; nel = 0; end
      2: if (!hs_req) begin nphase = 3; nel = 0; end
         else if (m_elapsed == MAXG - 1) begin nphase = 3; nel = 0; fired = 1'b1; end
      default: if (m_elapsed == REL - 1) begin nphase = 0; nel = 0; end
    endcase
    if (nphase != m_phase && nphase == 0) nel = 0;
    m_phase = nphase; m_elapsed = nel;
    if (fired) begin m_timeout = 1'b1; m_block = 1'b1; end
    else if (!hs_req) m_block = 1'b0;
  endtask

  task automatic compare_model();
    logic [AW-1:0] ea;
    logic [7:0]    ed;
    logic          ew;
    ea = (m_phase == 2) ? hs_address : core_address;
    ed = (m_phase == 2) ? hs_data : core_data;
    ew = (m_phase == 2) ? hs_write : (m_phase == 3) ? 1'b0 : core_write;
    check("rnd_outputs",
          {ram_address, ram_data, ram_we, pause, hs_grant, timeout, dropped_writes},
          {ea, ed, ew, (m_phase != 0), (m_phase == 2), m_timeout, 8'(m_drop)});
  endtask

  initial begin
    int n, g, seen;
    reset = 1'b0; vblank = 1'b0; hs_req = 1'b0; hs_write = 1'b0; core_write = 1'b0;
    hs_address = 10'h123; hs_data = 8'hA5; core_address = 10'h055; core_data = 8'h3C;

    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4};

    // Reset state
    do_reset();
    check("reset_pause", pause, 1'b0);
    check("reset_grant", hs_grant, 1'b0);
    check("reset_timeout", timeout, 1'b0);
    check("reset_dropped", dropped_writes, 8'd0);
    check("reset_mux_addr", ram_address, 10'h055);

    // Request held with vblank low must not pause the core
    hs_req = 1'b1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (pause || hs_grant) seen++;
    end
    check("gate_closed_quiet", seen, 0);

    for (int i = 0; i < 16; i++) begin
      vblank = vecs[i].vb; hs_req = vecs[i].req; core_write = vecs[i].cw; hs_write = vecs[i].hw;
      tick();
      check($sformatf("vec%0d_pause", i), pause, vecs[i].ep);
      check($sformatf("vec%0d_grant", i), hs_grant, vecs[i].eg);
      check($sformatf("vec%0d_we", i), ram_we, vecs[i].ewe);
      check($sformatf("vec%0d_addr", i), ram_address, vecs[i].eg ? 10'h123 : 10'h055);
      check($sformatf("vec%0d_data", i), ram_data, vecs[i].eg ? 8'hA5 : 8'h3C);
      check($sformatf("vec%0d_drop", i), dropped_writes, vecs[i].edrop);
    end
    core_write = 1'b0; hs_write = 1'b0;

    // Watchdog: 16 granted cycles, then release with sticky timeout
    do_reset();
    vblank = 1'b1; hs_req = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!hs_grant && n < 20);
    check("wd_grant_latency", n, SETTLE + 1);
    g = 0;
    while (hs_grant && g < 100) begin g++; tick(); end
    check("wd_grant_cycles", g, MAXG);
    check("wd_timeout_set", timeout, 1'b1);
    check("wd_release_pause", pause, 1'b1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i >= REL && (pause || hs_grant)) seen++;
    end
    check("wd_blocked_while_held", seen, 0);
    hs_req = 1'b0; tick();
    hs_req = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!hs_grant && n < 20);
    check("wd_regrant_latency", n, SETTLE + 1);
    check("wd_timeout_sticky", timeout, 1'b1);

    // Reset while granted
    core_write = 1'b1; tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0; core_write = 1'b0; hs_req = 1'b0;
    check("rst_mid_pause", pause, 1'b0);
    check("rst_mid_grant", hs_grant, 1'b0);
    check("rst_mid_dropped", dropped_writes, 8'd0);
    check("rst_mid_timeout", timeout, 1'b0);
    check("rst_mid_mux", ram_address, 10'h055);

    // Saturation of dropped writes across many grants
    core_write = 1'b1; vblank = 1'b1;
    for (int r = 0; r < 30; r++) begin
      hs_req = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!hs_grant && n < 20);
      for (int k = 0; k < 10; k++) tick();
      hs_req = 1'b0;
      for (int k = 0; k < REL + 2; k++) tick();
    end
    check("drop_saturate", dropped_writes, 8'd255);
    core_write = 1'b0;

    // Randomized traffic against the reference model
    do_reset();
    hs_req = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) hs_req = ~hs_req;
      if ($urandom_range(0, 3) == 0) vblank = ~vblank;
      core_write   = 1'($urandom_range(0, 1));
      hs_write     = 1'($urandom_range(0, 1));
      hs_address   = AW'($urandom);
      core_address = AW'($urandom);
      hs_data      = 8'($urandom);
      core_data    = 8'($urandom);
      reset        = ($urandom_range(0, 499) == 0);
      @(posedge clk);
      if (reset) begin
        m_phase = 0; m_elapsed = 0; m_timeout = 1'b0; m_block = 1'b0; m_drop = 0;
      end else begin
        model_step();
      end
      #1;
      compare_model();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
